mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
- Two-master arbiter sharing the tester's single external memory bus.
- Master 0 is the test controller fetching and storing vectors/results; master 1 is the host-side loader/unloader.
- Grants round-robin at transaction boundaries and tracks outstanding pipelined reads so each readdataready returns to the issuing master.
- Sits between test_controller and the memory controller inside the tester top level.

Parameters:
- ADDR_WIDTH, 20, memory word address width
- DATA_WIDTH, 16, data bus width
- BE_WIDTH, DATA_WIDTH/8, byteenable width
- MAX_PENDING, 4, max outstanding reads (power of two, >=2)

Ports:
- clock  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- m0_address / m1_address  in  ADDR_WIDTH  master address
- m0_byteenable / m1_byteenable  in  BE_WIDTH  master byte enables
- m0_read / m1_read  in  1  read request
- m0_write / m1_write  in  1  write request
- m0_writedata / m1_writedata  in  DATA_WIDTH  write data
- m0_waitrequest / m1_waitrequest  out  1  command not accepted; master holds command
- m0_readdata / m1_readdata  out  DATA_WIDTH  returned read data (broadcast of s_readdata)
- m0_readdataready / m1_readdataready  out  1  read data valid for that master
- s_address  out  ADDR_WIDTH  to memory controller
- s_byteenable  out  BE_WIDTH  to memory controller
- s_read  out  1  to memory controller
- s_write  out  1  to memory controller
- s_writedata  out  DATA_WIDTH  to memory controller
- s_waitrequest  in  1  from memory controller
- s_readdata  in  DATA_WIDTH  from memory controller
- s_readdataready  in  1  from memory controller, in issue order
- grant  out  2  one-hot current grant, 00 = idle
- pending  out  clog2(MAX_PENDING)+1  outstanding read count
- rd_err  out  1  sticky: readdataready with no outstanding read

Behaviour:
- Clocking and reset:
  - Reset is synchronous and active-high on the single clock.
  - Reset values: grant=00, s_read=s_write=0, s_address/s_byteenable/s_writedata=0, m*_waitrequest=1, m*_readdataready=0, pending=0, rd_err=0, rr pointer=master 0.
- Request definition: reqN = mN_read | mN_write. A master asserting both read and write is a protocol error; read wins.
- IDLE (grant=00):
  - Slave read/write held 0; both waitrequests 1.
  - At the next edge, grant goes to the single requester, or to the rr-pointer master if both request.
  - Arbitration costs one cycle from IDLE.
- GRANTED (grant=01 or 10):
  - Slave outputs combinationally mirror the granted master.
  - Granted master's waitrequest = s_waitrequest | blk, where blk = read request and pending==MAX_PENDING.
  - While blk: s_read is forced 0.
  - Non-granted master's waitrequest = 1.
- Acceptance: (s_read|s_write) & !s_waitrequest on an edge.
- On acceptance:
  - rr pointer becomes the other master.
  - If the other master is requesting in that cycle, grant switches to it at that edge; otherwise grant stays.
- Granted master not requesting in a cycle:
  - Grant moves to the other master if it is requesting, else to IDLE.
  - No command may be dropped mid-wait, so grant never changes while the granted master requests and waits.
- Tag FIFO (depth MAX_PENDING, 1-bit master ID):
  - Accepted read pushes the granted ID.
  - s_readdataready pops the head ID.
  - m{head}_readdataready = s_readdataready in the same cycle (combinational); the other master sees 0.
  - pending = push count minus pop count, updated at the edge.
  - Simultaneous push and pop leaves pending unchanged.
  - At pending==MAX_PENDING new reads are blocked even if a pop happens in the same cycle.
  - Pointers wrap modulo MAX_PENDING.
- Empty-FIFO read return: s_readdataready with pending==0 drives no m*_readdataready, sets rd_err, and leaves pending at 0. rd_err clears only on reset.
- Writes occupy no tag and complete on acceptance.
- Reset mid-operation: FIFO and grant clear immediately. Late s_readdataready after reset sets rd_err.

Test Plan:
- Single read, m0 only: m0_read at addr 0x00010, s_waitrequest=0, data 0xBEEF returned 3 cycles later -> grant=01 one cycle after request, s_read for 1 cycle, m0_readdataready with 0xBEEF, m1_readdataready 0, pending 0→1→0.
- Contention: both masters write continuously with s_waitrequest=0 -> accepted commands alternate m0,m1,m0,m1, and grant toggles every acceptance.
- Backpressure: m1 writes, s_waitrequest high 5 cycles while m0 requests -> grant stays 10 for all 5 cycles, m0_waitrequest=1, s_address/s_writedata stable; m0 granted at the acceptance edge.
- Read interleave: m0 reads A, m1 reads B, m0 reads C, data returned in order -> readdataready routed m0,m1,m0.
- Pending limit: MAX_PENDING=4 with no returns -> 5th read sees waitrequest=1 and s_read=0. One return releases it the following cycle (not the same cycle); pending max 4.
- Error/reset: s_readdataready with pending=0 -> rd_err=1 and stays 1. Reset mid-wait with 2 pending -> grant=00, pending=0, rd_err=0 the next cycle.

Source files
------------

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//   Two-master arbiter in front of the tester's single external memory bus.
//   Master 0 is the test controller, master 1 the host loader/unloader.
//   Grant rotates round-robin at command acceptance. A small tag FIFO
//   remembers which master issued each accepted read so that in-order read
//   returns are steered back to the issuer.
//
// Ports
//   clock, reset                 rising-edge clock, synchronous active-high reset
//   m0_* / m1_*                  master command ports (address, byteenable,
//                                read, write, writedata) and responses
//                                (waitrequest, readdata, readdataready)
//   s_*                          memory controller command/response port
//   grant                        one-hot current grant, 00 = idle
//   pending                      number of reads accepted but not yet returned
//   rd_err                       sticky: read data arrived with nothing pending
// -----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int ADDR_WIDTH  = 20,
    parameter int DATA_WIDTH  = 16,
    parameter int BE_WIDTH    = DATA_WIDTH / 8,
    parameter int MAX_PENDING = 4
) (
    input  logic                          clock,
    input  logic                          reset,

    input  logic [ADDR_WIDTH-1:0]         m0_address,
    input  logic [BE_WIDTH-1:0]           m0_byteenable,
    input  logic                          m0_read,
    input  logic                          m0_write,
    input  logic [DATA_WIDTH-1:0]         m0_writedata,
    output logic                          m0_waitrequest,
    output logic [DATA_WIDTH-1:0]         m0_readdata,
    output logic                          m0_readdataready,

    input  logic [ADDR_WIDTH-1:0]         m1_address,
    input  logic [BE_WIDTH-1:0]           m1_byteenable,
    input  logic                          m1_read,
    input  logic                          m1_write,
    input  logic [DATA_WIDTH-1:0]         m1_writedata,
    output logic                          m1_waitrequest,
    output logic [DATA_WIDTH-1:0]         m1_readdata,
    output logic                          m1_readdataready,

    output logic [ADDR_WIDTH-1:0]         s_address,
    output logic [BE_WIDTH-1:0]           s_byteenable,
    output logic                          s_read,
    output logic                          s_write,
    output logic [DATA_WIDTH-1:0]         s_writedata,
    input  logic                          s_waitrequest,
    input  logic [DATA_WIDTH-1:0]         s_readdata,
    input  logic                          s_readdataready,

    output logic [1:0]                    grant,
    output logic [$clog2(MAX_PENDING):0]  pending,
    output logic                          rd_err
);

    localparam int PW = $clog2(MAX_PENDING);
    localparam int CW = PW + 1;

    // State encoding doubles as the one-hot grant output.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_M0   = 2'b01,
        ST_M1   = 2'b10
    } state_t;

    state_t state, state_nxt;
    logic   rr, rr_nxt;                 // 0: master 0 wins a tie, 1: master 1

    logic                   req0, req1;
    logic                   g_read, g_write;
    logic                   full, blk, accept, push, pop;

    logic [MAX_PENDING-1:0] tag;        // issuing master ID per outstanding read
    logic [PW-1:0]          wr_ptr, rd_ptr;
    logic                   head;

    assign req0  = m0_read | m0_write;
    assign req1  = m1_read | m1_write;
    assign grant = state;

    // Slave command mux: mirror the granted master, drive zeros when idle.
    always_comb begin
        g_read       = 1'b0;
        g_write      = 1'b0;
        s_address    = '0;
        s_byteenable = '0;
        s_writedata  = '0;
        case (state)
            ST_M0: begin
                g_read       = m0_read;
                g_write      = m0_write;
                s_address    = m0_address;
                s_byteenable = m0_byteenable;
                s_writedata  = m0_writedata;
            end
            ST_M1: begin
                g_read       = m1_read;
                g_write      = m1_write;
                s_address    = m1_address;
                s_byteenable = m1_byteenable;
                s_writedata  = m1_writedata;
            end
            default: ;
        endcase
    end

    // A full tag FIFO blocks reads even if a return pops in the same cycle;
    // the freed slot is usable from the following cycle.
    assign full    = (pending == CW'(MAX_PENDING));
    assign blk     = g_read & full;
    assign s_read  = g_read & ~blk;
    assign s_write = g_write & ~g_read;   // read wins over a simultaneous write

    assign m0_waitrequest = (state == ST_M0) ? (s_waitrequest | blk) : 1'b1;
    assign m1_waitrequest = (state == ST_M1) ? (s_waitrequest | blk) : 1'b1;

    assign accept = (s_read | s_write) & ~s_waitrequest;
    assign push   = accept & s_read;
    assign pop    = s_readdataready & (pending != '0);

    // Read returns are in issue order, so the FIFO head names the owner.
    assign head             = tag[rd_ptr];
    assign m0_readdataready = pop & ~head;
    assign m1_readdataready = pop & head;
    assign m0_readdata      = s_readdata;
    assign m1_readdata      = s_readdata;

    // Grant only moves on acceptance or when the granted master lets go,
    // so a waiting command is never abandoned.
    always_comb begin
        state_nxt = state;
        rr_nxt    = rr;
        case (state)
            ST_IDLE: begin
                if (req0 & req1)
                    state_nxt = rr ? ST_M1 : ST_M0;
                else if (req0)
                    state_nxt = ST_M0;
                else if (req1)
                    state_nxt = ST_M1;
            end
            ST_M0: begin
                if (accept) begin
                    rr_nxt = 1'b1;
                    if (req1)
                        state_nxt = ST_M1;
                end else if (!req0) begin
                    state_nxt = req1 ? ST_M1 : ST_IDLE;
                end
            end
            ST_M1: begin
                if (accept) begin
                    rr_nxt = 1'b0;
                    if (req0)
                        state_nxt = ST_M0;
                end else if (!req1) begin
                    state_nxt = req0 ? ST_M0 : ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= ST_IDLE;
            rr      <= 1'b0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            pending <= '0;
            rd_err  <= 1'b0;
        end else begin
            state <= state_nxt;
            rr    <= rr_nxt;
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   pending <= pending + 1'b1;
                2'b01:   pending <= pending - 1'b1;
                default: ;
            endcase
            if (s_readdataready && pending == '0)
                rd_err <= 1'b1;
        end
    end

    // Tag storage needs no reset: entries are only read behind a push.
    always_ff @(posedge clock) begin
        if (!reset && push)
            tag[wr_ptr] <= (state == ST_M1);
    end

endmodule
